// File: rtl/memcopy_ctrl_engine.sv
// memcopy_ctrl_engine
//   Word-granular copy engine behind a 16-byte register window. Software
//   programs SRC, DST and SIZE (bytes); the SIZE write starts a copy of
//   SIZE>>2 words. Each word is moved as one OBI read followed by one OBI
//   write, with at most one transaction outstanding at any time.
//
//   Register map (byte offsets):
//     0x0 SRC    rw, bits[1:0] read 0
//     0x4 DST    rw, bits[1:0] read 0
//     0x8 SIZE   rw, a write starts the copy
//     0xC STATUS bit0 idle, bit1 done (sticky, clear-on-read),
//                bit2 interrupt enable (only with MEMCOPY_CTRL_INTR_EN)
//
//   Optional feature macro: MEMCOPY_CTRL_INTR_EN
//     defined   : STATUS bit2 is writable; done_intr_o pulses one cycle in
//                 DONE when bit2 is set.
//     undefined : done_intr_o tied low, STATUS bit2 reads 0, writes to 0xC
//                 are dropped.
//
//   Ports:
//     clk_i, rst_ni              clock, asynchronous active-low reset
//     reg_valid_i/reg_write_i    single-cycle register access strobe / dir
//     reg_addr_i, reg_wdata_i    byte offset and write data
//     reg_rdata_o, reg_ready_o   read data and ack, one cycle after access
//     obi_*                      OBI master (req/gnt, addr/we/be/wdata,
//                                rvalid/rdata)
//     done_intr_o                completion interrupt pulse
module memcopy_ctrl_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  reg_valid_i,
    input  logic                  reg_write_i,
    input  logic [3:0]            reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_ready_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [DATA_WIDTH-1:0] obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0] obi_rdata_i,
    output logic                  done_intr_o
);

    localparam logic [3:0] OFF_SRC    = 4'h0;
    localparam logic [3:0] OFF_DST    = 4'h4;
    localparam logic [3:0] OFF_SIZE   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;
    localparam int AW = ADDR_WIDTH - 2;
    localparam int CW = SIZE_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         src_q, src_d;
    logic [AW-1:0]         dst_q, dst_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic                  done_q, done_d;
    logic [31:0]           reg_rdata_q, reg_rdata_d;
    logic                  reg_ready_q, reg_ready_d;
    // Copy cursors and data register: always loaded before use, so no reset.
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         cur_src_q, cur_src_d;
    logic [AW-1:0]         cur_dst_q, cur_dst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic          intr_en;
    logic          reg_wr;
    logic          reg_rd;
    logic          idle;
    logic          size_wr;
    logic [CW-1:0] wr_words;

    assign reg_wr   = reg_valid_i & reg_write_i;
    assign reg_rd   = reg_valid_i & ~reg_write_i;
    assign idle     = (state_q == IDLE);
    // Programming registers only accept writes while idle; a busy write is dropped.
    assign size_wr  = reg_wr & idle & (reg_addr_i == OFF_SIZE);
    assign wr_words = reg_wdata_i[SIZE_WIDTH-1:2];

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        size_d = size_q;
        if (reg_wr && idle) begin
            case (reg_addr_i)
                OFF_SRC:  src_d  = reg_wdata_i[ADDR_WIDTH-1:2];
                OFF_DST:  dst_d  = reg_wdata_i[ADDR_WIDTH-1:2];
                OFF_SIZE: size_d = reg_wdata_i[SIZE_WIDTH-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        reg_rdata_d = '0;
        if (reg_rd) begin
            case (reg_addr_i)
                OFF_SRC:    reg_rdata_d = 32'({src_q, 2'b00});
                OFF_DST:    reg_rdata_d = 32'({dst_q, 2'b00});
                OFF_SIZE:   reg_rdata_d = 32'(size_q);
                OFF_STATUS: reg_rdata_d = {29'd0, intr_en, done_q, idle};
                default:    reg_rdata_d = '0;
            endcase
        end
    end

    assign reg_ready_d = reg_valid_i;

    // Completion set wins over a clear-on-read landing in the same cycle.
    always_comb begin
        done_d = done_q;
        if (reg_rd && (reg_addr_i == OFF_STATUS)) begin
            done_d = 1'b0;
        end
        if (state_q == DONE) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        data_d      = data_q;
        obi_req_o   = 1'b0;
        obi_we_o    = 1'b0;
        obi_addr_o  = '0;
        obi_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (size_wr) begin
                    if (wr_words == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d     = wr_words;
                        cur_src_d = src_q;
                        cur_dst_d = dst_q;
                        state_d   = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                obi_req_o  = 1'b1;
                obi_addr_o = {cur_src_q, 2'b00};
                if (obi_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (obi_rvalid_i) begin
                    data_d  = obi_rdata_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                obi_req_o   = 1'b1;
                obi_we_o    = 1'b1;
                obi_addr_o  = {cur_dst_q, 2'b00};
                obi_wdata_o = data_q;
                if (obi_gnt_i) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (obi_rvalid_i) begin
                    cnt_d     = cnt_q - CW'(1);
                    // Word-granular cursors wrap naturally at 2^32 bytes.
                    cur_src_d = cur_src_q + AW'(1);
                    cur_dst_d = cur_dst_q + AW'(1);
                    state_d   = (cnt_q == CW'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            size_q      <= '0;
            done_q      <= 1'b0;
            reg_rdata_q <= '0;
            reg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            size_q      <= size_d;
            done_q      <= done_d;
            reg_rdata_q <= reg_rdata_d;
            reg_ready_q <= reg_ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q     <= cnt_d;
        cur_src_q <= cur_src_d;
        cur_dst_q <= cur_dst_d;
        data_q    <= data_d;
    end

`ifdef MEMCOPY_CTRL_INTR_EN
    logic intr_en_q, intr_en_d;

    always_comb begin
        intr_en_d = intr_en_q;
        if (reg_wr && (reg_addr_i == OFF_STATUS)) begin
            intr_en_d = reg_wdata_i[2];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_en_q <= 1'b0;
        end else begin
            intr_en_q <= intr_en_d;
        end
    end

    assign intr_en = intr_en_q;
`else
    assign intr_en = 1'b0;
`endif

    assign done_intr_o = (state_q == DONE) & intr_en;
    assign obi_be_o    = 4'hF;
    assign reg_rdata_o = reg_rdata_q;
    assign reg_ready_o = reg_ready_q;

endmodule

// File: tb/tb_memcopy_ctrl_engine.sv
`timescale 1ns/1ps
module tb_memcopy_ctrl_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_valid_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [3:0]  reg_addr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic [31:0] reg_rdata_o;
    logic        reg_ready_o;
    logic        obi_req_o;
    logic        obi_gnt_i = 1'b0;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;
    logic        done_intr_o;

    memcopy_ctrl_engine dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_valid_i  (reg_valid_i),
        .reg_write_i  (reg_write_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rdata_o  (reg_rdata_o),
        .reg_ready_o  (reg_ready_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .done_intr_o  (done_intr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: memory image, expected OBI traffic, expected reg reads.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd_q [$];
    logic [63:0] exp_wr_q [$];
    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } reg_exp_t;
    reg_exp_t reg_q [$];

    int   wr_cnt = 0;
    int   intr_cnt = 0;
    int   intr_base = 0;
    int   gnt_min = 0, gnt_max = 0, rv_min = 1, rv_max = 1;
    bit   slv_busy = 0;
    logic exp_ien = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / not reached", name);
    endtask

    // OBI slave: random grant and response latency, checks protocol rules.
    initial begin : slave
        int          gcnt;
        int          rcnt;
        bit          hold;
        logic [31:0] rdat, h_addr, h_wdata;
        logic        h_we;
        logic [63:0] e;
        gcnt = 0; rcnt = 0; hold = 0; rdat = '0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0;
        forever begin
            @(negedge clk);
            obi_gnt_i    = 1'b0;
            obi_rvalid_i = 1'b0;
            if (!rst_n) begin
                slv_busy = 0;
                hold     = 0;
            end else if (slv_busy) begin
                chk("req_while_outstanding", 32'(obi_req_o), 32'd0);
                rcnt--;
                if (rcnt == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i  = rdat;
                    slv_busy     = 0;
                end
            end else begin
                if (hold) begin
                    chk("req_held", 32'(obi_req_o), 32'd1);
                    chk("addr_stable", obi_addr_o, h_addr);
                    chk("we_stable", 32'(obi_we_o), 32'(h_we));
                    chk("wdata_stable", obi_wdata_o, h_wdata);
                    if (!obi_req_o) hold = 0;
                end
                if (obi_req_o) begin
                    if (!hold) gcnt = int'($urandom_range(gnt_max, gnt_min));
                    if (gcnt == 0) begin
                        obi_gnt_i = 1'b1;
                        hold      = 0;
                        chk("be", 32'(obi_be_o), 32'hF);
                        if (obi_we_o) begin
                            wr_cnt++;
                            if (exp_wr_q.size() == 0) begin
                                fail_now("unexpected_write");
                            end else begin
                                e = exp_wr_q.pop_front();
                                chk("wr_addr", obi_addr_o, e[63:32]);
                                chk("wr_data", obi_wdata_o, e[31:0]);
                            end
                            mem[obi_addr_o] = obi_wdata_o;
                        end else begin
                            if (exp_rd_q.size() == 0) begin
                                fail_now("unexpected_read");
                            end else begin
                                chk("rd_addr", obi_addr_o, exp_rd_q.pop_front());
                            end
                            rdat = mem.exists(obi_addr_o) ? mem[obi_addr_o] : ~obi_addr_o;
                        end
                        slv_busy = 1;
                        rcnt = int'($urandom_range(rv_max, rv_min));
                    end else begin
                        hold    = 1;
                        gcnt--;
                        h_addr  = obi_addr_o;
                        h_we    = obi_we_o;
                        h_wdata = obi_wdata_o;
                    end
                end
            end
        end
    end

    // Register-response and interrupt monitor.
    initial begin : monitor
        reg_exp_t r;
        forever begin
            @(negedge clk);
            if (done_intr_o) intr_cnt++;
            if (reg_ready_o) begin
                if (reg_q.size() == 0) begin
                    fail_now("unexpected_reg_ready");
                end else begin
                    r = reg_q.pop_front();
                    if (r.is_rd) chk(r.name, reg_rdata_o, r.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] a, input logic we, input logic [31:0] d,
                         input logic [31:0] exp, input string name);
        reg_valid_i = 1'b1;
        reg_write_i = we;
        reg_addr_i  = a;
        reg_wdata_i = d;
        reg_q.push_back('{is_rd: !we, exp: exp, name: name});
    endtask

    task automatic bus_idle();
        reg_valid_i = 1'b0;
        reg_write_i = 1'b0;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(a, 1'b1, d, '0, "wr");
        if (a == 4'hC) begin
`ifdef MEMCOPY_CTRL_INTR_EN
            exp_ien = d[2];
`endif
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic reg_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        drive(a, 1'b0, '0, exp, name);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic set_slave(input int gmin, input int gmax, input int rmin, input int rmax);
        gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
    endtask

    // Model: N = SIZE[15:2] words, word i read at SRC&~3 + 4i, written at DST&~3 + 4i.
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] sz);
        int          n;
        logic [31:0] ra, wa;
        n = int'(sz[15:2]);
        for (int i = 0; i < n; i++) begin
            ra = (s & ~32'h3) + 32'(4 * i);
            wa = (d & ~32'h3) + 32'(4 * i);
            if (!mem.exists(ra)) mem[ra] = $urandom;
            exp_rd_q.push_back(ra);
            exp_wr_q.push_back({wa, mem[ra]});
        end
        wr_cnt    = 0;
        intr_base = intr_cnt;
        reg_wr(4'h0, s);
        reg_wr(4'h4, d);
        reg_wr(4'h8, sz);
    endtask

    task automatic wait_copy(input string tag, input int n_words);
        int t;
        t = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || slv_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now({tag, "_timeout"});
        repeat (3) @(negedge clk);
        chk({tag, "_wr_count"}, 32'(wr_cnt), 32'(n_words));
        chk({tag, "_intr_pulses"}, 32'(intr_cnt - intr_base), exp_ien ? 32'd1 : 32'd0);
        reg_rd(4'hC, {29'd0, exp_ien, 2'b11}, {tag, "_status_done"});
        reg_rd(4'hC, {29'd0, exp_ien, 2'b01}, {tag, "_status_clr"});
    endtask

    initial begin : main
        int          t;
        bit          found;
        logic [31:0] s, d, sz;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(obi_req_o), 32'd0);
        chk("rst_addr", obi_addr_o, 32'd0);
        chk("rst_we", 32'(obi_we_o), 32'd0);
        chk("rst_wdata", obi_wdata_o, 32'd0);
        chk("rst_be", 32'(obi_be_o), 32'hF);
        chk("rst_intr", 32'(done_intr_o), 32'd0);
        chk("rst_ready", 32'(reg_ready_o), 32'd0);
        chk("rst_rdata", reg_rdata_o, 32'd0);
        rst_n = 1'b1;
        reg_rd(4'hC, 32'h1, "rst_status");
        reg_rd(4'h0, 32'h0, "rst_src");
        reg_rd(4'h4, 32'h0, "rst_dst");
        reg_rd(4'h8, 32'h0, "rst_size");

        // Zero-wait 4-word copy with exact completion timing
        set_slave(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        start_copy(32'h1000, 32'h2000, 32'h10);
        repeat (16) @(negedge clk);
        drive(4'hC, 1'b0, '0, 32'h0, "status_before_done");
        @(negedge clk);
        drive(4'hC, 1'b0, '0, 32'h3, "status_18th_cycle");
        @(negedge clk);
        bus_idle();
        reg_rd(4'hC, 32'h1, "status_second_read");
        chk("zw_wr_count", 32'(wr_cnt), 32'd4);
        chk("zw_dst3", mem[32'h200C], 32'hA3);

        // Stalled slave: gnt after 3 cycles, rvalid 2 cycles after gnt
        set_slave(3, 3, 2, 2);
        start_copy(32'h3000, 32'h4000, 32'h8);
        wait_copy("stall", 2);

        // Zero-word copies
        set_slave(0, 1, 1, 2);
        start_copy(32'h3000, 32'h4000, 32'h0);
        wait_copy("size0", 0);
        start_copy(32'h3000, 32'h4000, 32'h3);
        wait_copy("size3", 0);
        reg_rd(4'h8, 32'h3, "size3_readback");

        // Writes while busy are dropped
        set_slave(1, 1, 1, 2);
        start_copy(32'h5000, 32'h6000, 32'h10);
        reg_wr(4'h8, 32'h100);
        reg_wr(4'h4, 32'h9000);
        reg_rd(4'h4, 32'h6000, "busy_dst_read");
        reg_rd(4'h8, 32'h10, "busy_size_read");
        reg_rd(4'h0, 32'h5000, "busy_src_read");
        wait_copy("busy", 4);
        reg_rd(4'h4, 32'h6000, "post_busy_dst");

        // Address wrap and low-bit masking
        set_slave(0, 2, 1, 2);
        start_copy(32'hFFFF_FFFB, 32'h0000_8001, 32'h10);
        reg_rd(4'h0, 32'hFFFF_FFF8, "src_low_bits");
        wait_copy("wrap", 4);

        // Unmapped offsets
        reg_wr(4'h2, 32'hDEAD_BEEF);
        reg_rd(4'h2, 32'h0, "unmapped_2");
        reg_rd(4'hE, 32'h0, "unmapped_e");

        // Interrupt enable
        set_slave(0, 1, 1, 1);
        reg_wr(4'hC, 32'h4);
        reg_rd(4'hC, {29'd0, exp_ien, 2'b01}, "ien_readback");
        start_copy(32'h3000, 32'hC000, 32'h4);
        wait_copy("intr_on", 1);
        reg_wr(4'hC, 32'h0);
        start_copy(32'h3000, 32'hC100, 32'h4);
        wait_copy("intr_off", 1);

        // Async reset during WR_REQ of word 2
        set_slave(3, 3, 1, 1);
        start_copy(32'h1000, 32'hA000, 32'h10);
        found = 0;
        t = 0;
        while (!found && t < 500) begin
            @(negedge clk);
            t++;
            if (obi_req_o && obi_we_o && wr_cnt == 1) found = 1;
        end
        if (!found) fail_now("reach_wr_req_word2");
        #1 rst_n = 1'b0;
        #1 chk("async_req_drop", 32'(obi_req_o), 32'd0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_ien = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reg_rd(4'hC, 32'h1, "post_rst_status");
        reg_rd(4'h0, 32'h0, "post_rst_src");
        start_copy(32'h1000, 32'hB000, 32'h4);
        wait_copy("post_rst", 1);
        chk("post_rst_data", mem[32'hB000], 32'hA0);

        // Randomized copies
        for (int k = 0; k < 8; k++) begin
            set_slave(0, int'($urandom_range(3, 0)), 1, int'($urandom_range(3, 1)));
            s  = 32'h0001_0000 + ({$urandom_range(4095, 0)} << 2) + {$urandom_range(3, 0)};
            d  = 32'h0080_0000 + ({$urandom_range(4095, 0)} << 2);
            sz = {$urandom_range(64, 0)};
            start_copy(s, d, sz);
            wait_copy("rand", int'(sz[15:2]));
        end

        repeat (4) @(negedge clk);
        chk("leftover_rd", 32'(exp_rd_q.size()), 32'd0);
        chk("leftover_wr", 32'(exp_wr_q.size()), 32'd0);
        chk("leftover_reg", 32'(reg_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
